// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int NREQ         = 3,
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd,
  input  logic                 pend_set,
  input  logic [AW-1:0]        pend_addr,
  output logic [(1<<AW)-1:0]   pend_bits,
  output logic [2:0]           grant_id
);

  logic [2:0]          ptr;
  logic [2:0]          gidx;
  logic                gvalid;
  logic                grant;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_data;
  logic [2:0]          ptr_nxt;
  logic [(1<<AW)-1:0]  pend_nxt;

  // Pick the valid requester with the smallest circular distance from ptr.
  always_comb begin
    int p;
    int off;
    int best;
    p      = int'(ptr);
    best   = NREQ;
    gvalid = 1'b0;
    gidx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      off = (i >= p) ? (i - p) : (i + NREQ - p);
      if (req_valid[i] && off < best) begin
        best   = off;
        gidx   = 3'(i);
        gvalid = 1'b1;
      end
    end
  end

  assign grant = gvalid & ~flush & ~reset;

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (gidx == 3'(i));
      if (gidx == 3'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign ptr_nxt = (gidx == 3'(NREQ-1)) ? 3'd0 : gidx + 3'd1;

  // Commit clear first, then issue set, so a same-edge re-issue keeps the bit.
  always_comb begin
    pend_nxt = pend_bits;
    if (rf_we)
      pend_nxt[rf_wa] = 1'b0;
    if (pend_set && !(ZERO_DISCARD && pend_addr == '0))
      pend_nxt[pend_addr] = 1'b1;
    if (flush)
      pend_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      grant_id  <= '0;
      pend_bits <= '0;
    end else begin
      pend_bits <= pend_nxt;
      if (grant) begin
        ptr      <= ptr_nxt;
        rf_wa    <= sel_addr;
        rf_wd    <= sel_data;
        grant_id <= gidx;
        rf_we    <= !(ZERO_DISCARD && sel_addr == '0);
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized check of regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            pend_set = 1'b0;
  logic [AW-1:0]   pend_addr = '0;
  logic [N-1:0]    req_valid = '0;
  logic [AW-1:0]   addr_a [N];
  logic [DW-1:0]   data_a [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [DW-1:0]   rf_wd;
  logic [31:0]     pend_bits;
  logic [2:0]      grant_id;

  int checks = 0;
  int failures = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr_a[i];
      req_data[i*DW +: DW] = data_a[i];
    end
  end

  regfile_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .ZERO_DISCARD(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_bits(pend_bits),
    .grant_id(grant_id)
  );

  // Behavioural model: circular search from a pointer, plain bit-vector scoreboard.
  int            m_ptr = 0;
  int            m_gid = 0;
  int            last_g = -1;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;
  logic [31:0]   m_pend = '0;

  function automatic int pick(logic [N-1:0] v, int p);
    logic [N-1:0] s;
    for (int k = 0; k < N; k++) begin
      s = v >> ((p + k) % N);
      if (s[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = pick(req_valid, m_ptr);
    if (!reset && !flush && g >= 0) r = N'(1) << g;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    int g;
    logic [31:0] np;
    if (reset) begin
      m_ptr <= 0; m_we <= 1'b0; m_wa <= '0; m_wd <= '0; m_gid <= 0;
      m_pend <= '0; last_g <= -1;
    end else begin
      g = flush ? -1 : pick(req_valid, m_ptr);
      np = m_pend;
      if (m_we) np[m_wa] = 1'b0;
      if (pend_set && pend_addr != 0) np[pend_addr] = 1'b1;
      if (flush) np = '0;
      m_pend <= np;
      last_g <= g;
      if (g >= 0) begin
        m_ptr <= (g + 1) % N;
        m_wa  <= addr_a[g];
        m_wd  <= data_a[g];
        m_gid <= g;
        m_we  <= (addr_a[g] != 0);
      end else begin
        m_we  <= 1'b0;
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("m_ready",  64'(req_ready), 64'(exp_ready()));
      chk("m_rf_we",  64'(rf_we),     64'(m_we));
      chk("m_rf_wa",  64'(rf_wa),     64'(m_wa));
      chk("m_rf_wd",  64'(rf_wd),     64'(m_wd));
      chk("m_gid",    64'(grant_id),  64'(m_gid));
      chk("m_pend",   64'(pend_bits), 64'(m_pend));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0;
      data_a[i] = '0;
    end
    tick();
    run_chk = 1'b1;
    at_neg();
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_pend", 64'(pend_bits), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    tick();
    reset = 1'b0;

    // single request from requester 1
    req_valid = 3'b010; addr_a[1] = 5'd5; data_a[1] = 32'hDEADBEEF;
    at_neg();
    chk("t1_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    at_neg();
    chk("t1_we", 64'(rf_we), 64'd1);
    chk("t1_wa", 64'(rf_wa), 64'd5);
    chk("t1_wd", 64'(rf_wd), 64'hDEADBEEF);
    chk("t1_gid", 64'(grant_id), 64'd1);
    tick();
    at_neg();
    chk("t1_we_off", 64'(rf_we), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // round-robin from ptr=0
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'(i + 1);
      data_a[i] = 32'h100 + 32'(i);
    end
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      at_neg();
      chk("rr_ready", 64'(req_ready), 64'(1) << (c % 3));
      if (c > 0) begin
        chk("rr_we", 64'(rf_we), 64'd1);
        chk("rr_gid", 64'(grant_id), 64'((c - 1) % 3));
      end
      tick();
    end
    req_valid = '0;
    at_neg();
    chk("rr_last_gid", 64'(grant_id), 64'd2);
    tick();

    // scoreboard set, commit clear, set wins on commit edge
    pend_set = 1'b1; pend_addr = 5'd7;
    tick();
    pend_set = 1'b0;
    req_valid = 3'b001; addr_a[0] = 5'd7; data_a[0] = 32'h77;
    at_neg();
    chk("sb_set", 64'(pend_bits[7]), 64'd1);
    tick();
    req_valid = '0;
    at_neg();
    chk("sb_commit_we", 64'(rf_we), 64'd1);
    chk("sb_still_set", 64'(pend_bits[7]), 64'd1);
    tick();
    at_neg();
    chk("sb_cleared", 64'(pend_bits[7]), 64'd0);
    pend_set = 1'b1; pend_addr = 5'd7;
    tick();
    pend_set = 1'b0; req_valid = 3'b001;
    tick();
    req_valid = '0; pend_set = 1'b1; pend_addr = 5'd7;
    tick();
    pend_set = 1'b0;
    at_neg();
    chk("sb_set_wins", 64'(pend_bits[7]), 64'd1);

    // r0 discarded
    req_valid = 3'b010; addr_a[1] = '0; data_a[1] = 32'h1234;
    pend_set = 1'b1; pend_addr = '0;
    at_neg();
    chk("r0_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0; pend_set = 1'b0;
    at_neg();
    chk("r0_we", 64'(rf_we), 64'd0);
    chk("r0_pend", 64'(pend_bits[0]), 64'd0);

    // flush
    pend_set = 1'b1; pend_addr = 5'd3;
    tick();
    pend_addr = 5'd9;
    tick();
    pend_set = 1'b0;
    at_neg();
    chk("fl_pend_before", 64'(pend_bits), 64'h288);
    req_valid = 3'b100; addr_a[2] = 5'd4; data_a[2] = 32'h44;
    flush = 1'b1; pend_set = 1'b1; pend_addr = 5'd12;
    at_neg();
    chk("fl_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0; pend_set = 1'b0;
    at_neg();
    chk("fl_pend", 64'(pend_bits), 64'd0);
    chk("fl_we", 64'(rf_we), 64'd0);
    chk("fl_regrant", 64'(req_ready), 64'b100);
    tick();
    req_valid = '0;
    at_neg();
    chk("fl_we2", 64'(rf_we), 64'd1);
    chk("fl_gid", 64'(grant_id), 64'd2);

    // asynchronous reset mid-cycle
    req_valid = 3'b001; addr_a[0] = 5'd10; data_a[0] = 32'hCAFE;
    pend_set = 1'b1; pend_addr = 5'd5;
    tick();
    req_valid = 3'b111; pend_set = 1'b0;
    at_neg();
    chk("ar_we_before", 64'(rf_we), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_we", 64'(rf_we), 64'd0);
    chk("ar_wa", 64'(rf_wa), 64'd0);
    chk("ar_wd", 64'(rf_wd), 64'd0);
    chk("ar_pend", 64'(pend_bits), 64'd0);
    chk("ar_ready", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    at_neg();
    chk("ar_ptr0", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    tick();

    // randomized traffic; requesters hold until granted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_g == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          addr_a[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          data_a[i] = $urandom;
        end
      end
      flush = ($urandom_range(0, 19) == 0);
      pend_set = 1'($urandom_range(0, 1));
      pend_addr = AW'($urandom);
      tick();
    end
    req_valid = '0; flush = 1'b0; pend_set = 1'b0;
    tick();
    tick();
    at_neg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard in front of the 32x32 register file's single write port. Up to NREQ producers (ALU, load unit, CSR/debug) offer writes through valid/ready handshakes. A round-robin arbiter grants one per cycle and drives the register file's we/wa/wd from a registered stage. A 32-bit scoreboard tracks registers with an issued-but-uncommitted write, which issue logic uses for hazard stalls.

## Interface

Parameters:
- NREQ, 3, number of write requesters (2..8)
- AW, 5, register address width
- DW, 32, data width
- ZERO_DISCARD, 1, when 1 writes to register 0 are accepted but never committed

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed data; requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; a handshake occurs when valid&ready
- rf_we  out  1  register-file write enable (registered)
- rf_wa  out  AW  register-file write address (registered)
- rf_wd  out  DW  register-file write data (registered)
- pend_set  in  1  issue logic marks pend_addr as pending
- pend_addr  in  AW  register being marked
- pend_bits  out  2^AW  scoreboard; bit r=1 means a write to r is outstanding
- grant_id  out  3  index of the last committed requester (debug)

## Operation

- Arbiter: combinational round-robin over req_valid, starting search at pointer ptr (0..NREQ-1). The first valid index found, g, gets req_ready[g]=1. All other ready bits are 0. If no request is valid, no grant.
- req_ready depends on req_valid and ptr only. Requesters must not make valid depend on ready. A requester holds valid, addr and data stable until it is granted.
- On a grant, at the clock edge: ptr <= (g+1) mod NREQ and the output stage loads wa=addr[g], wd=data[g], grant_id=g. rf_we <= 1, except rf_we <= 0 when ZERO_DISCARD=1 and addr[g]==0.
- No grant: rf_we <= 0. rf_wa, rf_wd and grant_id hold their values. ptr holds.
- Fairness: a continuously valid requester is granted within NREQ cycles.
- Scoreboard, evaluated per edge:
  - Clear bit rf_wa if rf_we=1.
  - Then set bit pend_addr if pend_set=1. Set wins when both address the same register.
  - Bit 0 is never set when ZERO_DISCARD=1.
- flush=1: all req_ready forced to 0 that cycle. At the edge, rf_we <= 0, pend_bits <= 0 and ptr holds. A pend_set in the same cycle is ignored. The register file still captures the rf_we=1 already presented during the flush cycle; flush only prevents new writes.

## Timing

- Reset values: rf_we=0, rf_wa=0, rf_wd=0, grant_id=0, ptr=0, pend_bits=0. req_ready=0 while reset is asserted.
- Reset mid-operation clears the output stage immediately. A write latched but not yet consumed by the register file is lost.
- Latency: handshake in cycle N produces rf_we=1 in cycle N+1, so the register file holds the data at the end of cycle N+1. Sustained throughput is one write per cycle.
- The pend_bits clear for a committed write is visible in cycle N+2, on the same edge the register file captures the data. A bit set by pend_set in cycle N is visible in cycle N+1.
- There is no back-pressure from the register file; the output stage never stalls.

## Test plan

- Reset, then a single request: req_valid=3'b010, addr=5, data=32'hDEADBEEF. Expect req_ready=3'b010 the same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=DEADBEEF, grant_id=1; the cycle after, rf_we=0.
- All three requesters valid for 6 cycles starting from ptr=0. Grant order must be 0,1,2,0,1,2; rf_we stays 1 continuously from the second cycle on.
- Scoreboard: pend_set with addr=7; pend_bits[7]=1 next cycle. Requester 0 then writes r7; bit 7 clears on the commit edge. A simultaneous pend_set=7 on that commit edge must leave bit 7 = 1.
- Write to r0 with data 32'h1234 and ZERO_DISCARD=1. The handshake occurs (req_ready=1), but rf_we stays 0 and pend_bits[0] stays 0.
- Flush: with bits 3 and 9 pending and requester 2 valid, assert flush for one cycle. Expect req_ready=0, then pend_bits=0 and rf_we=0. Requester 2 is granted in the cycle after flush deasserts.
- Asynchronous reset asserted mid-cycle while rf_we=1. rf_we, rf_wa, rf_wd and pend_bits go to 0 immediately, before the next clock edge; after release, the arbiter starts from ptr=0.
